// File: rtl/mvu_pkg.sv
// Shared types and elaboration helpers for the MVU weight streamer.
// The tile typedef is a macro because a package cannot carry the block's parameters.
`define MVU_WEIGHT_TILE_T(pe, simd, ww) logic [(pe)-1:0][(simd)-1:0][(ww)-1:0]

package mvu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_e;

  function automatic int calc_fold(input int dim, input int par);
    return dim / par;
  endfunction

  // Number of tiles: NF = MH/PE row folds times SF = MW/SIMD column folds.
  function automatic int calc_depth(input int mw, input int mh, input int pe, input int simd);
    return calc_fold(mh, pe) * calc_fold(mw, simd);
  endfunction

  function automatic int byte_align(input int w);
    return (w + 32'sd7) / 32'sd8 * 32'sd8;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

endpackage

// File: rtl/mvu_weight_streamer_if.sv
// Byte-aligned AXI-Stream carrying one weight tile per beat.
interface mvu_weight_streamer_if #(
  parameter int WB = 24
) ();
  logic [WB-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/mvu_weight_ram.sv
// Simple dual-port weight RAM: one write port, one read port with LAT output stages.
// Only the valid pipe is reset so the array itself can map onto block RAM.
module mvu_weight_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int LAT   = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata,
  output logic          o_rvld
);

  logic [DW-1:0]  r_mem  [DEPTH];
  logic [DW-1:0]  r_pipe [LAT];
  logic [LAT-1:0] r_vld;

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read data pipeline: first stage is the array read register
  always_ff @(posedge i_clk) begin
    r_pipe[0] <= r_mem[i_raddr];
    for (int i = 1; i < LAT; i++) begin
      r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Read valid pipeline, cleared by reset so no stale read survives
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= {LAT{1'b0}};
    end else begin
      r_vld[0] <= i_re;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  assign o_rdata = r_pipe[LAT-1];
  assign o_rvld  = r_vld[LAT-1];

endmodule

// File: rtl/mvu_weight_streamer.sv
// Replays the locally stored NF x SF weight tiles `reps` times as an AXI-Stream,
// with a credit-limited prefetch FIFO hiding RAM latency and backpressure.
module mvu_weight_streamer
  import mvu_pkg::*;
#(
  parameter  int MW           = 9,
  parameter  int MH           = 512,
  parameter  int PE           = 4,
  parameter  int SIMD         = 9,
  parameter  int WEIGHT_WIDTH = 8,
  parameter  int RAM_LAT      = 2,
  parameter  int REPS_WIDTH   = 16,
  localparam int DEPTH        = calc_depth(MW, MH, PE, SIMD),
  localparam int AW           = addr_width(DEPTH),
  localparam int DW           = PE * SIMD * WEIGHT_WIDTH,
  localparam int WB           = byte_align(DW)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [DW-1:0]         cfg_wdata,
  output logic                  cfg_rdy,
  input  logic                  start,
  input  logic [REPS_WIDTH-1:0] reps,
  output logic                  busy,
  output logic                  done,
  mvu_weight_streamer_if.master m_axis_weights
);

  localparam int FIFO_DEPTH = RAM_LAT + 2;
  localparam int OW         = $clog2(FIFO_DEPTH + 1);
  localparam int CW         = OW + 1;
  localparam int PW         = $clog2(FIFO_DEPTH);

  typedef `MVU_WEIGHT_TILE_T(PE, SIMD, WEIGHT_WIDTH) weight_tile_t;

  if ((MH % PE) != 0) begin : g_bad_pe
    $error("mvu_weight_streamer: PE must divide MH");
  end
  if ((MW % SIMD) != 0) begin : g_bad_simd
    $error("mvu_weight_streamer: SIMD must divide MW");
  end
  if ((RAM_LAT < 1) || (RAM_LAT > 3)) begin : g_bad_lat
    $error("mvu_weight_streamer: RAM_LAT must be 1..3");
  end

  stream_state_e         r_state;
  logic [AW-1:0]         r_addr;
  logic [AW-1:0]         r_rd_addr;
  logic                  r_rd_en;
  logic [REPS_WIDTH-1:0] r_reps;
  logic [REPS_WIDTH-1:0] r_rep;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cfg_rdy;
  weight_tile_t          r_fifo_mem [FIFO_DEPTH];
  logic [OW-1:0]         r_fifo_occ;
  logic [OW-1:0]         r_inflight;
  logic                  r_tvalid;

  logic                  w_ram_we;
  logic                  w_ram_vld;
  logic [DW-1:0]         w_ram_rdata;
  weight_tile_t          w_ram_tile;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_last_addr;
  logic                  w_last_rep;
  logic [CW-1:0]         w_used;
  logic [CW-1:0]         w_limit;
  logic [OW-1:0]         w_occ_nxt;
  logic [OW-1:0]         w_inflight_nxt;
  logic [PW-1:0]         w_push_idx;

  assign w_ram_we   = cfg_we && (r_state == ST_IDLE);
  assign w_ram_tile = w_ram_rdata;

  mvu_weight_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW),
    .LAT   (RAM_LAT)
  ) u_ram (
    .i_clk   (ap_clk),
    .i_rst   (ap_rst),
    .i_we    (w_ram_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_wdata),
    .i_re    (r_rd_en),
    .i_raddr (r_rd_addr),
    .o_rdata (w_ram_rdata),
    .o_rvld  (w_ram_vld)
  );

  // Credit check: a slot freed by this cycle's pop may be reused at once, keeping 1 beat/cycle
  always_comb begin
    w_pop          = r_tvalid & m_axis_weights.tready;
    w_used         = CW'(r_fifo_occ) + CW'(r_inflight);
    w_limit        = CW'(FIFO_DEPTH) + CW'(w_pop);
    w_issue        = (r_state == ST_FETCH) && (w_used < w_limit);
    w_occ_nxt      = r_fifo_occ + OW'(w_ram_vld) - OW'(w_pop);
    w_inflight_nxt = r_inflight + OW'(w_issue) - OW'(w_ram_vld);
    w_push_idx     = w_pop ? PW'(r_fifo_occ - OW'(1)) : PW'(r_fifo_occ);
    w_last_addr    = (r_addr == AW'(DEPTH - 1));
    w_last_rep     = (r_rep == (r_reps - REPS_WIDTH'(1)));
  end

  // Sequencer: start handling, read issue with address/rep wrap, drain and done
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= {AW{1'b0}};
      r_rd_addr <= {AW{1'b0}};
      r_rd_en   <= 1'b0;
      r_reps    <= {REPS_WIDTH{1'b0}};
      r_rep     <= {REPS_WIDTH{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_rdy <= 1'b1;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (reps != {REPS_WIDTH{1'b0}}) begin
              r_reps    <= reps;
              r_addr    <= {AW{1'b0}};
              r_rep     <= {REPS_WIDTH{1'b0}};
              r_busy    <= 1'b1;
              r_cfg_rdy <= 1'b0;
              r_state   <= ST_FETCH;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (w_issue) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_addr;
            if (w_last_addr) begin
              r_addr <= {AW{1'b0}};
              r_rep  <= r_rep + REPS_WIDTH'(1);
              if (w_last_rep) begin
                r_state <= ST_DRAIN;
              end
            end else begin
              r_addr <= r_addr + AW'(1);
            end
          end
        end
        ST_DRAIN: begin
          // Finish on the edge that retires the last beat, so done follows it directly
          if ((w_occ_nxt == {OW{1'b0}}) && (w_inflight_nxt == {OW{1'b0}})) begin
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_cfg_rdy <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_cfg_rdy <= 1'b1;
        end
      endcase
    end
  end

  // Occupancy, reads in flight and output valid
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_fifo_occ <= {OW{1'b0}};
      r_inflight <= {OW{1'b0}};
      r_tvalid   <= 1'b0;
    end else begin
      r_fifo_occ <= w_occ_nxt;
      r_inflight <= w_inflight_nxt;
      r_tvalid   <= (w_occ_nxt != {OW{1'b0}});
    end
  end

  // Shift FIFO storage: head is always entry 0; a push lands after the shift
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_mem[i] <= {DW{1'b0}};
      end
    end else begin
      if (w_pop) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
          r_fifo_mem[i] <= r_fifo_mem[i+1];
        end
      end
      if (w_ram_vld) begin
        r_fifo_mem[w_push_idx] <= w_ram_tile;
      end
    end
  end

  assign m_axis_weights.tdata  = WB'(r_fifo_mem[0]);
  assign m_axis_weights.tvalid = r_tvalid;
  assign cfg_rdy               = r_cfg_rdy;
  assign busy                  = r_busy;
  assign done                  = r_done;

endmodule

// File: tb/tb_mvu_weight_streamer.sv
// Randomized self-checking bench: the expected stream is rebuilt from a RAM image
// as reps x (addr 0..DEPTH-1), independent of how the streamer sequences its reads.
module tb_mvu_weight_streamer;

  localparam int MW      = 6;
  localparam int MH      = 4;
  localparam int PE      = 2;
  localparam int SIMD    = 3;
  localparam int WW      = 3;
  localparam int RAM_LAT = 2;
  localparam int RW      = 16;
  localparam int DEPTH   = 4;
  localparam int AW      = 2;
  localparam int DW      = 18;
  localparam int WB      = 24;
  localparam int FD      = RAM_LAT + 2;

  logic          ap_clk    = 1'b0;
  logic          ap_rst    = 1'b1;
  logic          cfg_we    = 1'b0;
  logic [AW-1:0] cfg_addr  = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          cfg_rdy;
  logic          start     = 1'b0;
  logic [RW-1:0] reps      = '0;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] ram_model [DEPTH];

  mvu_weight_streamer_if #(.WB(WB)) axis ();

  mvu_weight_streamer #(
    .MW           (MW),
    .MH           (MH),
    .PE           (PE),
    .SIMD         (SIMD),
    .WEIGHT_WIDTH (WW),
    .RAM_LAT      (RAM_LAT),
    .REPS_WIDTH   (RW)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cfg_rdy        (cfg_rdy),
    .start          (start),
    .reps           (reps),
    .busy           (busy),
    .done           (done),
    .m_axis_weights (axis.master)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] d);
    @(posedge ap_clk);
    #1;
    check_eq("cfg_rdy_idle", 32'(cfg_rdy), 32'd1);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(a);
    cfg_wdata = d;
    ram_model[a] = d;
    @(posedge ap_clk);
    #1;
    cfg_we = 1'b0;
  endtask

  // One start request; cycle 0 is the cycle right after the edge that samples start.
  task automatic run(input int r, input int ready_pct, input bit chk_timing,
                     input bit poke_cfg, input int rst_after);
    logic [DW-1:0] exp_q[$];
    logic [WB-1:0] prev_data = '0;
    bit stall = 1'b0;
    int lat = -1, hs_cyc = -1, done_cyc = -1, beats = 0;
    for (int rp = 0; rp < r; rp++)
      for (int a = 0; a < DEPTH; a++)
        exp_q.push_back(ram_model[a]);
    @(posedge ap_clk);
    #1;
    start = 1'b1;
    reps = RW'(r);
    axis.tready = ($urandom_range(0, 99) < ready_pct);
    @(posedge ap_clk);
    #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge ap_clk);
      if (stall) begin
        check_eq("hold_tvalid", 32'(axis.tvalid), 32'd1);
        check_eq("hold_tdata", 32'(axis.tdata), 32'(prev_data));
      end
      if (axis.tvalid && lat < 0) lat = cyc;
      check_eq("fifo_occ_bound", 32'(int'(dut.r_fifo_occ) <= FD), 32'd1);
      if (done) begin
        done_cyc = cyc;
        check_eq("busy_at_done", 32'(busy), 32'd0);
        check_eq("cfg_rdy_at_done", 32'(cfg_rdy), 32'd1);
        break;
      end
      check_eq("busy_run", 32'(busy), 32'd1);
      check_eq("cfg_rdy_run", 32'(cfg_rdy), 32'd0);
      if (axis.tvalid && axis.tready) begin
        check_eq("tdata_pad", 32'(axis.tdata[WB-1:DW]), 32'd0);
        beats++;
        if (exp_q.size() == 0) check_eq("beat_count", 32'(beats), 32'(r * DEPTH));
        else check_eq("beat_data", 32'(axis.tdata[DW-1:0]), 32'(exp_q.pop_front()));
        hs_cyc = cyc;
      end
      stall = axis.tvalid && !axis.tready;
      prev_data = axis.tdata;
      if (rst_after > 0 && beats == rst_after) break;
      @(posedge ap_clk);
      #1;
      axis.tready = ($urandom_range(0, 99) < ready_pct);
      cfg_we = poke_cfg && (cyc == 1);
    end
    cfg_we = 1'b0;
    if (rst_after > 0) begin
      check_eq("beats_before_rst", 32'(beats), 32'(rst_after));
      @(posedge ap_clk);
      #1;
      ap_rst = 1'b1;
      @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      @(negedge ap_clk);
      check_eq("rst_tvalid", 32'(axis.tvalid), 32'd0);
      check_eq("rst_tdata", 32'(axis.tdata), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_cfg_rdy", 32'(cfg_rdy), 32'd1);
      check_eq("rst_done", 32'(done), 32'd0);
    end else begin
      check_eq("done_within_budget", 32'(done_cyc >= 0), 32'd1);
      check_eq("beats_total", 32'(beats), 32'(r * DEPTH));
      check_eq("exp_left", 32'(exp_q.size()), 32'd0);
      check_eq("done_after_last", 32'(done_cyc), 32'(hs_cyc + 1));
      if (chk_timing) begin
        check_eq("first_valid_lat", 32'(lat), 32'(RAM_LAT + 2));
        check_eq("no_bubbles", 32'(hs_cyc), 32'(RAM_LAT + 2 + r * DEPTH - 1));
      end
      @(negedge ap_clk);
      check_eq("done_one_cycle", 32'(done), 32'd0);
      check_eq("idle_tvalid", 32'(axis.tvalid), 32'd0);
    end
  endtask

  task automatic run_zero_reps();
    @(posedge ap_clk);
    #1;
    start = 1'b1;
    reps = '0;
    axis.tready = 1'b1;
    @(posedge ap_clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      check_eq("zero_done", 32'(done), 32'(i == 0));
      check_eq("zero_busy", 32'(busy), 32'd0);
      check_eq("zero_tvalid", 32'(axis.tvalid), 32'd0);
    end
  endtask

  initial begin
    axis.tready = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check_eq("reset_tvalid", 32'(axis.tvalid), 32'd0);
    check_eq("reset_tdata", 32'(axis.tdata), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_cfg_rdy", 32'(cfg_rdy), 32'd1);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;

    for (int a = 0; a < DEPTH; a++) write_word(a, DW'(32'h1000 + a));
    run(2, 100, 1'b1, 1'b0, 0);
    run(2, 30, 1'b0, 1'b0, 0);
    run_zero_reps();

    cfg_addr  = AW'(1);
    cfg_wdata = 18'h3FFFF;
    run(1, 100, 1'b1, 1'b1, 0);

    run(2, 100, 1'b0, 1'b0, 3);
    run(1, 100, 1'b1, 1'b0, 0);

    for (int it = 0; it < 3; it++) begin
      for (int a = 0; a < DEPTH; a++) write_word(a, DW'($urandom));
      run(int'($urandom_range(1, 3)), (it == 0) ? 100 : 50, it == 0, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mvu_weight_streamer.md
Name: mvu_weight_streamer

Overview:
Transmitter for the weight stream of mvu_vvu_axi: holds the full NF x SF weight tile set in a local RAM and replays it as a byte-aligned AXI-Stream into s_axis_weights_*. The RAM is loaded through a simple write port. Each start request replays the whole matrix `reps` times, once per image. The block absorbs RAM read latency and downstream backpressure with a small prefetch FIFO, so it sustains 1 beat/cycle.

Parameters:
MW, 9, matrix width (SIMD must divide MW)
MH, 512, matrix height (PE must divide MH)
PE, 4, rows per beat
SIMD, 9, columns per beat
WEIGHT_WIDTH, 8, bits per weight
RAM_LAT, 2, RAM read latency in cycles (1..3)
REPS_WIDTH, 16, width of the repetition count

Ports:
ap_clk  in  1  single clock; all logic is rising-edge
ap_rst  in  1  synchronous, active-high reset
cfg_we  in  1  RAM write strobe
cfg_addr  in  AW=max(1,$clog2(NF*SF))  word address; tile (i,j) is stored at i*SF+j
cfg_wdata  in  PE*SIMD*WEIGHT_WIDTH  tile data, packed [PE][SIMD][WEIGHT_WIDTH]
cfg_rdy  out  1  high when writes are accepted (IDLE only)
start  in  1  single-cycle start request
reps  in  REPS_WIDTH  number of full-matrix replays, sampled together with start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last beat handshake
m_axis_weights_tdata  out  WB=(PE*SIMD*WEIGHT_WIDTH+7)/8*8  tile in the low bits, upper pad bits are 0
m_axis_weights_tvalid  out  1
m_axis_weights_tready  in  1

Behaviour:
- Derived constants: NF=MH/PE, SF=MW/SIMD, DEPTH=NF*SF. Elaboration $error if MH%PE or MW%SIMD is nonzero.
- Reset values: tvalid=0, tdata=0, busy=0, done=0, cfg_rdy=1. Reset also clears the FIFO, counters and FSM. RAM contents are preserved.
- Reset mid-run: tvalid=0 on the first edge after ap_rst is high. No partial state survives.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: if start && reps!=0, latch reps, set addr=0 and rep=0, go to FETCH.
  - IDLE: if start && reps==0, go nowhere and pulse done in the next cycle.
  - IDLE: cfg_we is honoured only here; cfg_rdy = (state==IDLE).
- FETCH: issue one RAM read per cycle while credits remain. Credits = FIFO_DEPTH - occupancy - reads in flight, with FIFO_DEPTH=RAM_LAT+2.
  - addr increments on each issued read. At DEPTH-1 it wraps to 0 and rep increments.
  - After the read for addr=DEPTH-1 in rep=reps-1 is issued, go to DRAIN.
- DRAIN: when the FIFO is empty and no reads are in flight, pulse done, clear busy, go to IDLE.
- Latency: start sampled at edge k; first read issued in cycle k+1; first tvalid rises at edge k+RAM_LAT+2.
- Throughput with tready held high: back-to-back beats, no bubbles across matrix wraps or reps.
- AXI rules:
  - tdata/tvalid are driven from the FIFO head.
  - Once tvalid=1, tvalid and tdata stay stable until tready=1.
  - tvalid never depends combinationally on tready.
- FIFO full: no read issued, so there is no overflow under any tready pattern. Simultaneous push and pop at full is legal and keeps occupancy.
- start while busy: ignored. cfg_we while not IDLE: ignored, with no RAM change.
- Total beats per start = reps*DEPTH, in order addr 0..DEPTH-1 for each rep.

Decomposition:
- Package mvu_pkg entries:
  - weight_tile_t, logic [PE-1:0][SIMD-1:0][WEIGHT_WIDTH-1:0] via parameterised typedef macro
  - NF/SF/DEPTH computation function
  - byte-align function (w+7)/8*8
  - FSM state enum
- One sub-module: mvu_weight_ram, a simple dual-port RAM with 1 write port, 1 read port and RAM_LAT output register stages. It is behavioural so synthesis infers BRAM/URAM.

Test Plan (PE=2, SIMD=3, WEIGHT_WIDTH=3, MW=6, MH=4 → NF=2, SF=2, DEPTH=4, WB=24; word n = 18'h1000+n):
- Load words 0..3, start with reps=2, tready=1 → start at edge k, tvalid at k+4. 8 consecutive beats, tdata 24'h001000,001001,001002,001003 repeated. done 1 cycle after the last beat.
- Same run with tready random (≈30% high) → identical 8-beat sequence. tdata stable while tvalid && !tready. FIFO occupancy never exceeds 4.
- start with reps=0 → no tvalid; done pulses 1 cycle later; busy stays 0.
- cfg_we to addr 1 with 18'h3FFFF while busy, then rerun with reps=1 → addr 1 still emits 24'h001001. cfg_rdy=0 during the run.
- Assert ap_rst for 1 cycle after beat 3 of a reps=2 run → tvalid=0 at the next edge, busy=0, cfg_rdy=1. A new start with reps=1 emits 24'h001000..001003 correctly.
- tdata upper 6 bits checked as 0 on every beat of every scenario.
